// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    ZERO    = 3'd2,
    SIGNFIX = 3'd3,
    DONE    = 3'd4
  } div_state_t;

  // Iteration counter must hold WIDTH-1; keep at least one bit for tiny widths.
  function automatic int div_count_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam int DIV_COUNT_W = div_count_width(DIV_WIDTH_DEFAULT);

endpackage

// File: rtl/ripple_subtractor.sv
// Ripple subtractor A - B = A + ~B + 1 built from a chain of full-adder cells.
// borrow is the inverted final carry: high when B > A.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module ripple_subtractor #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N:0]   carry_s;
  logic [N-1:0] b_inv_s;

  assign b_inv_s    = ~b;
  assign carry_s[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_cell
    full_adder u_fa (
      .a    (a[i]),
      .b    (b_inv_s[i]),
      .cin  (carry_s[i]),
      .sum  (diff[i]),
      .cout (carry_s[i+1])
    );
  end

  assign borrow = ~carry_s[N];

endmodule

// File: rtl/restoring_divider_8.sv
// Multi-cycle restoring divider with start/done handshake, one trial subtraction per clock.
// Optional DIV_SIGNED_EN: two's-complement operands with an extra SIGNFIX cycle.
module restoring_divider_8
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = div_count_width(WIDTH);

  div_state_t       state_r;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] dvd_r;

  logic [WIDTH:0]   r_shift_s;
  logic [WIDTH:0]   sub_diff_s;
  logic             sub_borrow_s;
  logic [WIDTH:0]   rem_nxt_s;
  logic [WIDTH-1:0] quo_nxt_s;
  logic             rem_top_unused_s;

`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic q_neg_r;
  logic r_neg_r;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  // MIN maps to itself, which reads correctly as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? negate(v) : v;
  endfunction
`endif

  // The top remainder bit is always zero once restored; it only widens the subtractor.
  assign rem_top_unused_s = rem_r[WIDTH];
  assign r_shift_s        = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};

  ripple_subtractor #(
    .N (WIDTH + 1)
  ) u_sub (
    .a      (r_shift_s),
    .b      ({1'b0, dvs_r}),
    .diff   (sub_diff_s),
    .borrow (sub_borrow_s)
  );

  // Restore on borrow, otherwise keep the difference and shift in a quotient one.
  always_comb begin
    rem_nxt_s = r_shift_s;
    quo_nxt_s = {quo_r[WIDTH-2:0], 1'b0};
    if (sub_borrow_s) begin
      rem_nxt_s = r_shift_s;
      quo_nxt_s = {quo_r[WIDTH-2:0], 1'b0};
    end else begin
      rem_nxt_s = sub_diff_s;
      quo_nxt_s = {quo_r[WIDTH-2:0], 1'b1};
    end
  end

  // Control FSM, working registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      count_r     <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      dvs_r       <= '0;
      dvd_r       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvd_r       <= dividend;
            rem_r       <= '0;
            count_r     <= CNT_W'(WIDTH - 1);
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
`ifdef DIV_SIGNED_EN
            quo_r       <= magnitude(dividend);
            dvs_r       <= magnitude(divisor);
            q_neg_r     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_r     <= dividend[WIDTH-1];
`else
            quo_r       <= dividend;
            dvs_r       <= divisor;
`endif
            state_r     <= (divisor == '0) ? ZERO : RUN;
          end
        end

        RUN: begin
          rem_r   <= rem_nxt_s;
          quo_r   <= quo_nxt_s;
          count_r <= count_r - CNT_W'(1);
          if (count_r == '0) begin
`ifdef DIV_SIGNED_EN
            state_r   <= SIGNFIX;
`else
            quotient  <= quo_nxt_s;
            remainder <= rem_nxt_s[WIDTH-1:0];
            done      <= 1'b1;
            busy      <= 1'b0;
            state_r   <= DONE;
`endif
          end
        end

        ZERO: begin
          quotient    <= {WIDTH{1'b1}};
          remainder   <= dvd_r;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          busy        <= 1'b0;
          state_r     <= DONE;
        end

        SIGNFIX: begin
`ifdef DIV_SIGNED_EN
          // Quotient truncates toward zero; remainder follows the dividend's sign.
          quotient  <= q_neg_r ? negate(quo_r) : quo_r;
          remainder <= r_neg_r ? negate(rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];
          done      <= 1'b1;
          busy      <= 1'b0;
          state_r   <= DONE;
`else
          done      <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
`endif
        end

        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end

        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider_8.sv
// Directed-vector bench for restoring_divider_8; honours DIV_SIGNED_EN when defined.
module tb_restoring_divider_8;

`ifdef DIV_SIGNED_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 9;
`endif
  localparam int MAX_CYC = 30;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  restoring_divider_8 #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present operands for one cycle; returns #1 after the accepting edge (cycle 1).
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'h5A;
    divisor  = 8'h00;
  endtask

  // Wait for done starting at cycle cyc0; checks latency, busy and result hold.
  task automatic wait_done(input string tag, input int cyc0, input int exp_lat,
                           input logic [7:0] held_q);
    int  cyc;
    logic busy_ok;
    logic held_ok;
    cyc     = cyc0;
    busy_ok = 1'b1;
    held_ok = 1'b1;
    while (done !== 1'b1 && cyc < MAX_CYC) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (quotient !== held_q) held_ok = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, ".latency"}, 8'(cyc), 8'(exp_lat));
    check({tag, ".busy_run"}, 8'(busy_ok), 8'd1);
    check({tag, ".held"}, 8'(held_ok), 8'd1);
    check({tag, ".busy_done"}, 8'(busy), 8'd0);
  endtask

  task automatic check_result(input string tag, input logic [7:0] eq,
                              input logic [7:0] er, input logic ez);
    check({tag, ".q"}, quotient, eq);
    check({tag, ".r"}, remainder, er);
    check({tag, ".dbz"}, 8'(div_by_zero), 8'(ez));
    @(posedge clk);
    #1;
    check({tag, ".done_width"}, 8'(done), 8'd0);
  endtask

  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic ez,
                         input int lat);
    logic [7:0] prev_q;
    prev_q = quotient;
    issue(a, b);
    wait_done(tag, 1, lat, prev_q);
    check_result(tag, eq, er, ez);
  endtask

  function automatic logic [15:0] ref_div(input logic [7:0] a, input logic [7:0] b);
`ifdef DIV_SIGNED_EN
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return {8'(sa / sb), 8'(sa % sb)};
`else
    return {a / b, a % b};
`endif
  endfunction

  initial begin
    logic [7:0]  prev_q;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] exp_qr;
    int          done_seen;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = 8'h00;
    divisor  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", 8'(busy), 8'd0);
    check("reset.done", 8'(done), 8'd0);
    check("reset.q", quotient, 8'h00);
    check("reset.r", remainder, 8'h00);
    check("reset.dbz", 8'(div_by_zero), 8'd0);
    rst = 1'b0;

    run_div("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, LAT);
    run_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, LAT);
    run_div("d3_10", 8'd3, 8'd10, 8'd0, 8'd3, 1'b0, LAT);
    run_div("d0_5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0, LAT);
    run_div("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, LAT);
    run_div("d5_0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 2);
    run_div("d9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, LAT);

    // Start pulse while busy must be ignored.
    prev_q = quotient;
    issue(8'd200, 8'd9);
    repeat (3) @(posedge clk);
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore", 5, LAT, prev_q);
`ifdef DIV_SIGNED_EN
    check_result("ignore", 8'hFA, 8'hFE, 1'b0);
`else
    check_result("ignore", 8'd22, 8'd2, 1'b0);
`endif

    // Reset in the middle of an operation abandons it.
    issue(8'd200, 8'd9);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst.busy", 8'(busy), 8'd0);
    check("midrst.done", 8'(done), 8'd0);
    check("midrst.q", quotient, 8'h00);
    check("midrst.r", remainder, 8'h00);
    check("midrst.dbz", 8'(div_by_zero), 8'd0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) done_seen++;
      @(posedge clk);
      #1;
    end
    check("midrst.no_done", 8'(done_seen), 8'd0);
    run_div("d17_4", 8'd17, 8'd4, 8'd4, 8'd1, 1'b0, LAT);

    // Start held high restarts in the first idle cycle after done.
    @(negedge clk);
    dividend = 8'd20;
    divisor  = 8'd3;
    start    = 1'b1;
    prev_q   = quotient;
    @(posedge clk);
    #1;
    wait_done("hold1", 1, LAT, prev_q);
    check("hold1.q", quotient, 8'd6);
    @(posedge clk);
    #1;
    check("hold.idle_busy", 8'(busy), 8'd0);
    @(posedge clk);
    #1;
    check("hold.restart_busy", 8'(busy), 8'd1);
    start = 1'b0;
    wait_done("hold2", 1, LAT, 8'd6);
    check_result("hold2", 8'd6, 8'd2, 1'b0);

`ifdef DIV_SIGNED_EN
    run_div("s_m100_7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, LAT);
    run_div("s_min_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, LAT);
    run_div("s_7_m2", 8'd7, 8'hFE, 8'hFD, 8'h01, 1'b0, LAT);
`endif

    for (int i = 0; i < 12; i++) begin
      ra     = 8'($urandom_range(0, 255));
      rb     = 8'($urandom_range(1, 255));
      exp_qr = ref_div(ra, rb);
      run_div($sformatf("rnd%0d_%0d_%0d", i, ra, rb), ra, rb,
              exp_qr[15:8], exp_qr[7:0], 1'b0, LAT);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
